// File: rtl/leb128_byte_framer.sv
`default_nettype none
// ============================================================================
// Module   : leb128_byte_framer
// Purpose  : Collects a serial LEB128 byte stream into one packed frame per
//            encoded number, in the layout the LEB128 unpack stages consume.
//            Holds one finished frame until it is taken. Unused bytes are
//            zero. The block reports the byte count, and it flags and drains
//            encodings longer than MB bytes.
// Ports    : clk      - clock, rising edge
//            rst_n    - asynchronous active-low reset
//            s_data   - stream byte; bit7 = continuation, bits 6:0 = payload
//            s_valid  - s_data valid
//            s_ready  - byte accepted this cycle when high with s_valid
//            m_frame  - packed frame [0:M-1]; byte k occupies bits k*8..k*8+7
//            m_len    - number of bytes in the frame, 1..MB
//            m_err    - frame truncated at MB bytes (over-long encoding)
//            m_valid  - m_frame/m_len/m_err valid
//            m_ready  - downstream takes the frame
// Revision : 1.0 - initial release
// ============================================================================
module leb128_byte_framer #(
  parameter int N = 64,
  localparam int MB = N / 7 + 1,
  localparam int M = MB * 8,
  localparam int LEN_W = $clog2(MB + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [0:M-1]     m_frame,
  output logic [LEN_W-1:0] m_len,
  output logic             m_err,
  output logic             m_valid,
  input  logic             m_ready
);

  localparam int c_idx_w = (MB > 1) ? $clog2(MB) : 1;
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(MB - 1);
  localparam logic [c_idx_w-1:0] c_idx_one  = c_idx_w'(1);
  localparam logic [LEN_W-1:0]   c_len_one  = LEN_W'(1);
  localparam logic [LEN_W-1:0]   c_len_max  = LEN_W'(MB);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_HOLD    = 2'd1,
    S_DRAIN   = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [c_idx_w-1:0] r_idx;
  logic [c_idx_w-1:0] w_idx_next;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   w_len_next;
  logic               r_err;
  logic               w_err_next;
  logic [0:M-1]       r_frame;
  logic [0:M-1]       w_frame_next;
  logic               w_load;    // write s_data into byte slot r_idx
  logic               w_clr;     // wipe the frame after a handshake
  logic [0:7]         w_byte_fmt;
  logic [MB-1:0]      w_hit;

  // Frame byte order: continuation flag first, then payload LSB..MSB.
  assign w_byte_fmt[0] = s_data[7];
  for (genvar j = 0; j < 7; j++) begin : g_payload
    assign w_byte_fmt[j+1] = s_data[j];
  end

  for (genvar k = 0; k < MB; k++) begin : g_byte
    localparam logic [c_idx_w-1:0] c_k = c_idx_w'(k);
    assign w_hit[k] = w_load && (r_idx == c_k);
    assign w_frame_next[k*8 +: 8] = w_clr    ? 8'h00 :
                                    w_hit[k] ? w_byte_fmt :
                                               r_frame[k*8 +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_COLLECT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_len_next   = r_len;
    w_err_next   = r_err;
    w_load       = 1'b0;
    w_clr        = 1'b0;
    s_ready      = 1'b0;
    m_valid      = 1'b0;

    case (r_state)
      S_COLLECT: begin
        s_ready = 1'b1;
        if (s_valid) begin
          w_load = 1'b1;
          if (!s_data[7]) begin
            w_len_next   = LEN_W'(r_idx) + c_len_one;
            w_err_next   = 1'b0;
            w_state_next = S_HOLD;
          end else if (r_idx == c_last_idx) begin
            // Slot MB-1 filled and the number still continues: truncate.
            w_len_next   = c_len_max;
            w_err_next   = 1'b1;
            w_state_next = S_HOLD;
          end else begin
            w_idx_next = r_idx + c_idx_one;
          end
        end
      end

      S_HOLD: begin
        m_valid = 1'b1;
        if (m_ready) begin
          w_clr        = 1'b1;
          w_idx_next   = '0;
          // m_err stays up through DRAIN so the tail is attributed to it.
          w_state_next = r_err ? S_DRAIN : S_COLLECT;
        end
      end

      S_DRAIN: begin
        s_ready = 1'b1;
        if (s_valid && !s_data[7]) begin
          w_err_next   = 1'b0;
          w_state_next = S_COLLECT;
        end
      end

      default: begin
        w_state_next = S_COLLECT;
        w_idx_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_len   <= '0;
      r_err   <= 1'b0;
      r_frame <= '0;
    end else begin
      r_idx   <= w_idx_next;
      r_len   <= w_len_next;
      r_err   <= w_err_next;
      r_frame <= w_frame_next;
    end
  end

  assign m_frame = r_frame;
  assign m_len   = r_len;
  assign m_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_leb128_byte_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_leb128_byte_framer
// Purpose  : Self-checking bench for leb128_byte_framer (N=64). Directed
//            cases plus random stream with random stalls; expected frames are
//            produced by a byte-list reference model and checked by a
//            scoreboard monitor at every output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_leb128_byte_framer;

  localparam int N     = 64;
  localparam int MB    = 10;
  localparam int M     = 80;
  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [7:0]       s_data;
  logic             s_valid;
  logic             s_ready;
  logic [0:M-1]     m_frame;
  logic [LEN_W-1:0] m_len;
  logic             m_err;
  logic             m_valid;
  logic             m_ready;

  leb128_byte_framer #(.N(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .m_frame (m_frame),
    .m_len   (m_len),
    .m_err   (m_err),
    .m_valid (m_valid),
    .m_ready (m_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [0:M-1] frame;
    int           len;
    logic         err;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [7:0]  cur_bytes[$];
  bit          draining = 1'b0;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int rise_cyc    = -1;
  int last_acc_cyc = 0;
  int frames_seen = 0;
  logic         prev_valid = 1'b0;
  logic [0:M-1] last_frame;
  int           last_len = 0;
  logic         last_err = 1'b0;

  function automatic void chk(input string name, input logic [127:0] act,
                              input logic [127:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endfunction

  // Reference model: gather accepted bytes into a list, close it on a
  // terminating byte or at MB bytes, then skip to the end of an over-long number.
  function automatic void model_reset();
    cur_bytes.delete();
    draining = 1'b0;
    exp_q.delete();
  endfunction

  function automatic void model_accept(input logic [7:0] b);
    exp_t e;
    if (draining) begin
      if (!b[7]) draining = 1'b0;
      return;
    end
    cur_bytes.push_back(b);
    if (!b[7] || cur_bytes.size() == MB) begin
      e.frame = '0;
      e.len   = cur_bytes.size();
      e.err   = b[7];
      for (int k = 0; k < cur_bytes.size(); k++) begin
        e.frame[k*8] = cur_bytes[k][7];
        for (int j = 0; j < 7; j++) e.frame[k*8+1+j] = cur_bytes[k][j];
      end
      exp_q.push_back(e);
      if (b[7]) draining = 1'b1;
      cur_bytes.delete();
    end
  endfunction

  function automatic logic [63:0] dec_u(input logic [0:M-1] f, input int len);
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < len; k++)
      for (int j = 0; j < 7; j++)
        if (7*k + j < 64) v[7*k+j] = f[k*8+1+j];
    return v;
  endfunction

  function automatic logic [63:0] dec_s(input logic [0:M-1] f, input int len);
    logic [63:0] v;
    int nb;
    v  = dec_u(f, len);
    nb = 7 * len;
    if (nb < 64 && nb > 0 && v[nb-1])
      for (int i = nb; i < 64; i++) v[i] = 1'b1;
    return v;
  endfunction

  always @(posedge clk) cyc++;

  // Scoreboard monitor: pops and compares at each output handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (m_valid && !prev_valid) rise_cyc = cyc;
      if (m_valid) chk("len_nonzero", 128'(m_len != '0), 128'd1);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_frame: got len %0d err %0b expected no frame", m_len, m_err);
        end else begin
          mon_e = exp_q.pop_front();
          chk("frame_bits", 128'(m_frame), 128'(mon_e.frame));
          chk("frame_len", 128'(m_len), 128'(mon_e.len));
          chk("frame_err", 128'(m_err), 128'(mon_e.err));
        end
        last_frame = m_frame;
        last_len   = int'(m_len);
        last_err   = m_err;
        frames_seen++;
      end
      prev_valid = m_valid;
    end
  end

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    s_data  = b;
    s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: got s_ready 0 expected 1 for byte %0h", b);
      s_valid = 1'b0;
      return;
    end
    last_acc_cyc = cyc;
    model_accept(b);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int n;
    n = 0;
    while (frames_seen < target && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("frame_arrival", 128'(frames_seen >= target), 128'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 128'(m_valid), 128'd0);
    chk({tag, "_ready"}, 128'(s_ready), 128'd1);
    chk({tag, "_len"},   128'(m_len),   128'd0);
    chk({tag, "_err"},   128'(m_err),   128'd0);
    chk({tag, "_frame"}, 128'(m_frame), 128'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int first_cyc;
    int ready_low;
    bit rnd_done;

    s_data  = '0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    rst_n   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single byte 0x7F
    m_ready = 1'b1;
    send(8'h7F);
    wait_frames(1);
    chk("t1_len", 128'(last_len), 128'd1);
    chk("t1_err", 128'(last_err), 128'd0);
    chk("t1_frame", 128'(last_frame), 128'({8'h7F, 72'h0}));
    chk("t1_unsigned", 128'(dec_u(last_frame, last_len)), 128'd127);
    chk("t1_signed", 128'(dec_s(last_frame, last_len)), 128'(64'hFFFF_FFFF_FFFF_FFFF));

    // Three bytes back-to-back: latency and single bubble
    send(8'hE5);
    first_cyc = last_acc_cyc;
    send(8'h8E);
    send(8'h26);
    ready_low = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (!s_ready) ready_low++;
    end
    chk("t2_latency", 128'(rise_cyc - first_cyc), 128'd3);
    chk("t2_ready_low", 128'(ready_low), 128'd1);
    wait_frames(2);
    chk("t2_len", 128'(last_len), 128'd3);
    chk("t2_unsigned", 128'(dec_u(last_frame, last_len)), 128'd624485);

    // Downstream stall in HOLD with a pending upstream byte
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    send(8'h2A);
    fork
      send(8'h01);
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("t3_stall_valid", 128'(m_valid), 128'd1);
          chk("t3_stall_ready", 128'(s_ready), 128'd0);
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
      end
    join
    wait_frames(4);
    chk("t3_len", 128'(last_len), 128'd1);
    chk("t3_value", 128'(dec_u(last_frame, last_len)), 128'd1);

    // Over-long: eleven 0x80 then 0x00, then 0x05
    for (int i = 0; i < 11; i++) send(8'h80);
    send(8'h00);
    send(8'h05);
    wait_frames(6);
    chk("t4_len", 128'(last_len), 128'd1);
    chk("t4_err", 128'(last_err), 128'd0);
    chk("t4_value", 128'(dec_u(last_frame, last_len)), 128'd5);

    // Reset in the middle of a number
    send(8'h80);
    send(8'h80);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(8'h02);
    wait_frames(7);
    chk("t5_len", 128'(last_len), 128'd1);
    chk("t5_err", 128'(last_err), 128'd0);
    chk("t5_value", 128'(dec_u(last_frame, last_len)), 128'd2);

    // Random stream with random upstream gaps and downstream stalls
    rnd_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          int len;
          len = int'($urandom_range(1, 12));
          for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 3) == 0) begin
              repeat ($urandom_range(1, 3)) @(posedge clk);
              #1;
            end
            send({(i != len - 1), 7'($urandom)});
          end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          m_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    m_ready = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    chk("rand_queue_empty", 128'(exp_q.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
